// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with bubble insertion, stall hold and a saturating bubble counter
module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 10,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               noOp_i,
    input  logic               flush_i,
    input  logic               stall_i,
    input  logic               valid_i,
    input  logic               RegWrite_i,
    input  logic               MemtoReg_i,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    input  logic               ALUSrc_i,
    input  logic [1:0]         ALUOp_i,
    input  logic [DATA_W-1:0]  RS1data_i,
    input  logic [DATA_W-1:0]  RS2data_i,
    input  logic [DATA_W-1:0]  Imm_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [4:0]         RS1addr_i,
    input  logic [4:0]         RS2addr_i,
    input  logic [4:0]         RDaddr_i,
    output logic               valid_o,
    output logic               RegWrite_o,
    output logic               MemtoReg_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               ALUSrc_o,
    output logic [1:0]         ALUOp_o,
    output logic [DATA_W-1:0]  RS1data_o,
    output logic [DATA_W-1:0]  RS2data_o,
    output logic [DATA_W-1:0]  Imm_o,
    output logic [FUNCT_W-1:0] funct_o,
    output logic [4:0]         RS1addr_o,
    output logic [4:0]         RS2addr_o,
    output logic [4:0]         RDaddr_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    logic               valid_q, valid_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic               alu_src_q, alu_src_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic [DATA_W-1:0]  rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0]  rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [FUNCT_W-1:0] funct_q, funct_d;
    logic [4:0]         rs1_addr_q, rs1_addr_d;
    logic [4:0]         rs2_addr_q, rs2_addr_d;
    logic [4:0]         rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic               bubble;

    // Next state: stall holds everything (remembering a flush), otherwise load with control zeroed on a bubble
    always_comb begin
        bubble       = !stall_i && (flush_i || flush_pend_q || noOp_i);
        flush_pend_d = stall_i && (flush_pend_q || flush_i);
        valid_d      = stall_i ? valid_q      : (!bubble && valid_i);
        reg_write_d  = stall_i ? reg_write_q  : (!bubble && RegWrite_i);
        mem_to_reg_d = stall_i ? mem_to_reg_q : (!bubble && MemtoReg_i);
        mem_read_d   = stall_i ? mem_read_q   : (!bubble && MemRead_i);
        mem_write_d  = stall_i ? mem_write_q  : (!bubble && MemWrite_i);
        alu_src_d    = stall_i ? alu_src_q    : (!bubble && ALUSrc_i);
        alu_op_d     = stall_i ? alu_op_q     : (bubble ? 2'b00 : ALUOp_i);
        rd_addr_d    = stall_i ? rd_addr_q    : (bubble ? 5'd0 : RDaddr_i);
        rs1_data_d   = stall_i ? rs1_data_q   : RS1data_i;
        rs2_data_d   = stall_i ? rs2_data_q   : RS2data_i;
        imm_d        = stall_i ? imm_q        : Imm_i;
        funct_d      = stall_i ? funct_q      : funct_i;
        rs1_addr_d   = stall_i ? rs1_addr_q   : RS1addr_i;
        rs2_addr_d   = stall_i ? rs2_addr_q   : RS2addr_i;
        cnt_d        = (bubble && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State register, cleared asynchronously by an active-low reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            funct_q      <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rd_addr_q    <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            alu_src_q    <= alu_src_d;
            alu_op_q     <= alu_op_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            funct_q      <= funct_d;
            rs1_addr_q   <= rs1_addr_d;
            rs2_addr_q   <= rs2_addr_d;
            rd_addr_q    <= rd_addr_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign valid_o      = valid_q;
    assign RegWrite_o   = reg_write_q;
    assign MemtoReg_o   = mem_to_reg_q;
    assign MemRead_o    = mem_read_q;
    assign MemWrite_o   = mem_write_q;
    assign ALUSrc_o     = alu_src_q;
    assign ALUOp_o      = alu_op_q;
    assign RS1data_o    = rs1_data_q;
    assign RS2data_o    = rs2_data_q;
    assign Imm_o        = imm_q;
    assign funct_o      = funct_q;
    assign RS1addr_o    = rs1_addr_q;
    assign RS2addr_o    = rs2_addr_q;
    assign RDaddr_o     = rd_addr_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: scoreboard bench comparing the ID/EX register against a rule-level reference model
module tb_id_ex_pipe_reg;
    localparam int DW = 32;
    localparam int FW = 10;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          rw, m2r, mr, mw, as;
        logic [1:0]    aop;
        logic [DW-1:0] rs1d, rs2d, imm;
        logic [FW-1:0] funct;
        logic [4:0]    rs1a, rs2a, rda;
        logic          valid;
        logic [CW-1:0] cnt;
    } out_t;
    localparam int OW = $bits(out_t);

    logic clk_i = 1'b0;
    logic rst_i;
    logic noOp_i, flush_i, stall_i, valid_i;
    logic RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
    logic [1:0] ALUOp_i;
    logic [DW-1:0] RS1data_i, RS2data_i, Imm_i;
    logic [FW-1:0] funct_i;
    logic [4:0] RS1addr_i, RS2addr_i, RDaddr_i;
    logic valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
    logic [1:0] ALUOp_o;
    logic [DW-1:0] RS1data_o, RS2data_o, Imm_o;
    logic [FW-1:0] funct_o;
    logic [4:0] RS1addr_o, RS2addr_o, RDaddr_o;
    logic [CW-1:0] bubble_cnt_o;

    id_ex_pipe_reg #(.DATA_W(DW), .FUNCT_W(FW), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .noOp_i(noOp_i), .flush_i(flush_i), .stall_i(stall_i),
        .valid_i(valid_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i), .RS1data_i(RS1data_i),
        .RS2data_i(RS2data_i), .Imm_i(Imm_i), .funct_i(funct_i), .RS1addr_i(RS1addr_i),
        .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i), .valid_o(valid_o), .RegWrite_o(RegWrite_o),
        .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o),
        .ALUOp_o(ALUOp_o), .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o),
        .funct_o(funct_o), .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    out_t act;
    assign act = out_t'({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
                         RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
                         valid_o, bubble_cnt_o});

    out_t exp_q[$];
    out_t m_out = '0;
    bit   m_pend = 1'b0;
    int   m_cnt = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [OW-1:0] a, input logic [OW-1:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    // Monitor: every registered output update is compared against the next scoreboard entry
    always @(posedge clk_i) begin
        #1;
        if (exp_q.size() > 0) check("pipe_out", act, exp_q.pop_front());
    end

    task automatic rand_fields();
        valid_i = 1'($urandom); RegWrite_i = 1'($urandom); MemtoReg_i = 1'($urandom);
        MemRead_i = 1'($urandom); MemWrite_i = 1'($urandom); ALUSrc_i = 1'($urandom);
        ALUOp_i = 2'($urandom); RS1data_i = $urandom; RS2data_i = $urandom; Imm_i = $urandom;
        funct_i = FW'($urandom); RS1addr_i = 5'($urandom); RS2addr_i = 5'($urandom);
        RDaddr_i = 5'($urandom);
    endtask

    // Reference: apply the edge rules to the current inputs, queue the result, advance one cycle
    task automatic tick();
        out_t n = m_out;
        bit b;
        if (stall_i) begin
            if (flush_i) m_pend = 1'b1;
        end else begin
            b = flush_i || m_pend || noOp_i;
            m_pend = 1'b0;
            n.rs1d = RS1data_i; n.rs2d = RS2data_i; n.imm = Imm_i; n.funct = funct_i;
            n.rs1a = RS1addr_i; n.rs2a = RS2addr_i;
            if (b) begin
                n.rw = 0; n.m2r = 0; n.mr = 0; n.mw = 0; n.as = 0; n.aop = 0; n.rda = 0; n.valid = 0;
                m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
            end else begin
                n.rw = RegWrite_i; n.m2r = MemtoReg_i; n.mr = MemRead_i; n.mw = MemWrite_i;
                n.as = ALUSrc_i; n.aop = ALUOp_i; n.rda = RDaddr_i; n.valid = valid_i;
            end
            n.cnt = CW'(m_cnt);
        end
        m_out = n;
        exp_q.push_back(n);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        exp_q.delete();
        m_out = '0; m_pend = 1'b0; m_cnt = 0;
        #1 check("reset_mid", act, '0);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b0; noOp_i = 0; flush_i = 0; stall_i = 0;
        rand_fields();
        RegWrite_i = 1'b1; RDaddr_i = 5'd5;
        #1 check("reset_async", act, '0);
        @(negedge clk_i);
        check("reset_held", act, '0);
        rst_i = 1'b1;

        rand_fields(); valid_i = 1; RegWrite_i = 1; MemRead_i = 1; RDaddr_i = 7; Imm_i = 32'h10;
        tick();
        check("load_rd", OW'(RDaddr_o), OW'(7));
        check("load_imm", OW'(Imm_o), OW'(32'h10));
        check("load_valid", OW'({valid_o, RegWrite_o, MemRead_o}), OW'(3'b111));

        noOp_i = 1; MemRead_i = 1; RDaddr_i = 7;
        tick();
        noOp_i = 0;
        check("noop_ctrl", OW'({MemRead_o, RDaddr_o, valid_o}), '0);
        check("noop_cnt", OW'(bubble_cnt_o), OW'(1));

        rand_fields(); valid_i = 1; stall_i = 1;
        tick();
        flush_i = 1; noOp_i = 1;
        tick();
        flush_i = 0; noOp_i = 0;
        tick();
        check("stall_cnt", OW'(bubble_cnt_o), OW'(1));
        stall_i = 0; rand_fields(); valid_i = 1;
        tick();
        check("pend_bubble", OW'({valid_o, bubble_cnt_o}), OW'({1'b0, 4'd2}));

        rand_fields(); flush_i = 1; noOp_i = 1;
        tick();
        check("flush_noop_cnt", OW'(bubble_cnt_o), OW'(3));
        flush_i = 0;

        repeat (20) begin rand_fields(); tick(); end
        check("cnt_saturate", OW'(bubble_cnt_o), OW'(4'hF));
        noOp_i = 0; stall_i = 1; flush_i = 1;
        tick();
        tick();
        do_reset();
        stall_i = 0; flush_i = 0; rand_fields(); valid_i = 1;
        tick();
        check("no_bubble_after_reset", OW'({valid_o, bubble_cnt_o}), OW'({1'b1, 4'd0}));

        for (int i = 0; i < 600; i++) begin
            rand_fields();
            stall_i = ($urandom_range(3) == 0);
            flush_i = ($urandom_range(5) == 0);
            noOp_i = ($urandom_range(3) == 0);
            if ($urandom_range(99) == 0) do_reset();
            else tick();
        end
        stall_i = 0; flush_i = 0; noOp_i = 0;
        tick();

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
